// File: rtl/sd_sector_cache_if.sv
// rtl/sd_sector_cache_if.sv - memory bus read port of the SD sector cache
// Ports: address/enable driven by the bus master (CPU side);
//        data_out/busy returned by the cache (slave side).
interface sd_sector_cache_if #(
    parameter int ADDR_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  enable;
    logic [7:0]            data_out;
    logic                  busy;

    modport master (
        output address,
        output enable,
        input  data_out,
        input  busy
    );

    modport slave (
        input  address,
        input  enable,
        output data_out,
        output busy
    );
endinterface

// File: rtl/sd_sector_cache.sv
// rtl/sd_sector_cache.sv - single-sector read cache in front of the SD sector reader
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   bus               memory bus read port (address, enable -> data_out, busy)
//   fill_req/sector   sector read request to the SD back end, held until fill_ack
//   fill_ack          back end accepted the request
//   fill_data/valid   streamed sector bytes
//   fill_done/error   end of sector / back end failure
//   invalidate        drop the cached sector
//   error             sticky fill failure flag
//   fill_count        completed-fill counter (modulo 256)
module sd_sector_cache #(
    parameter int ADDR_WIDTH  = 24,
    parameter int SECTOR_BITS = 9
) (
    input  logic                              clk,
    input  logic                              reset,
    sd_sector_cache_if.slave                  bus,
    output logic                              fill_req,
    output logic [ADDR_WIDTH-SECTOR_BITS-1:0] fill_sector,
    input  logic                              fill_ack,
    input  logic [7:0]                        fill_data,
    input  logic                              fill_valid,
    input  logic                              fill_done,
    input  logic                              fill_error,
    input  logic                              invalidate,
    output logic                              error,
    output logic [7:0]                        fill_count
);
    localparam int TAG_W        = ADDR_WIDTH - SECTOR_BITS;
    localparam int SECTOR_BYTES = 1 << SECTOR_BITS;
    localparam logic [SECTOR_BITS:0] FULL_CNT = (SECTOR_BITS + 1)'(SECTOR_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    logic [1:0]             state;
    logic                   line_valid;
    logic [TAG_W-1:0]       tag;
    logic [SECTOR_BITS:0]   byte_cnt;
    logic [SECTOR_BITS:0]   cnt_next;
    logic                   inv_pend;
    logic [SECTOR_BITS-1:0] rd_addr_q;
    logic [7:0]             rd_data;
    logic [7:0]             mem [SECTOR_BYTES];

    logic [TAG_W-1:0]       addr_tag;
    logic [SECTOR_BITS-1:0] addr_idx;
    logic                   hit;
    logic                   byte_in;

    assign addr_tag = bus.address[ADDR_WIDTH-1:SECTOR_BITS];
    assign addr_idx = bus.address[SECTOR_BITS-1:0];
    assign hit      = line_valid && (tag == addr_tag);

    // Bytes past the end of the sector are dropped rather than wrapping onto byte 0.
    assign byte_in  = reset && (state == ST_FILL) && fill_valid && (byte_cnt != FULL_CNT);
    assign cnt_next = byte_cnt + (SECTOR_BITS + 1)'(byte_in);

    always_ff @(posedge clk) begin
        if (byte_in) begin
            mem[byte_cnt[SECTOR_BITS-1:0]] <= fill_data;
        end
    end

    // Read port runs every cycle; rd_addr_q tells us whether rd_data belongs
    // to the address currently on the bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data   <= 8'h00;
            rd_addr_q <= '0;
        end else begin
            rd_data   <= mem[addr_idx];
            rd_addr_q <= addr_idx;
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        case (state)
            ST_IDLE: bus.busy = bus.enable && !(hit && (rd_addr_q == addr_idx));
            ST_REQ:  bus.busy = 1'b1;
            ST_FILL: bus.busy = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

    assign bus.data_out = (state == ST_FAIL) ? 8'hFF : rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            line_valid  <= 1'b0;
            tag         <= '0;
            fill_req    <= 1'b0;
            fill_sector <= '0;
            byte_cnt    <= '0;
            inv_pend    <= 1'b0;
            error       <= 1'b0;
            fill_count  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (invalidate) begin
                        line_valid <= 1'b0;
                    end
                    if (bus.enable && !hit) begin
                        state       <= ST_REQ;
                        fill_sector <= addr_tag;
                        fill_req    <= 1'b1;
                        inv_pend    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (invalidate) begin
                        inv_pend <= 1'b1;
                    end
                    if (fill_ack) begin
                        state    <= ST_FILL;
                        fill_req <= 1'b0;
                        byte_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    byte_cnt <= cnt_next;
                    if (invalidate) begin
                        inv_pend <= 1'b1;
                    end
                    // Done is judged on the count including a byte arriving in the same cycle.
                    if (fill_error || (fill_done && (cnt_next != FULL_CNT))) begin
                        line_valid <= 1'b0;
                        error      <= 1'b1;
                        state      <= ST_FAIL;
                    end else if (fill_done) begin
                        if (inv_pend || invalidate) begin
                            line_valid <= 1'b0;
                        end else begin
                            line_valid <= 1'b1;
                            tag        <= fill_sector;
                        end
                        error      <= 1'b0;
                        fill_count <= fill_count + 8'd1;
                        state      <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_cache.sv
// tb/tb_sd_sector_cache.sv - directed self-checking bench for sd_sector_cache
module tb_sd_sector_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        fill_req;
    logic [14:0] fill_sector;
    logic        fill_ack;
    logic [7:0]  fill_data;
    logic        fill_valid;
    logic        fill_done;
    logic        fill_error;
    logic        invalidate;
    logic        error;
    logic [7:0]  fill_count;

    int vectors     = 0;
    int miscompares = 0;

    sd_sector_cache_if bus ();

    sd_sector_cache dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fill_req    (fill_req),
        .fill_sector (fill_sector),
        .fill_ack    (fill_ack),
        .fill_data   (fill_data),
        .fill_valid  (fill_valid),
        .fill_done   (fill_done),
        .fill_error  (fill_error),
        .invalidate  (invalidate),
        .error       (error),
        .fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams bytes start..start+n-1 with value idx[7:0]^xr; optionally raises
    // fill_done together with the last byte.
    task automatic stream(input int start, input int n, input logic [7:0] xr, input bit done_last);
        for (int i = start; i < start + n; i++) begin
            fill_valid = 1'b1;
            fill_data  = 8'(i) ^ xr;
            fill_done  = done_last && (i == start + n - 1);
            tick();
        end
        fill_valid = 1'b0;
        fill_done  = 1'b0;
    endtask

    task automatic ack();
        fill_ack = 1'b1;
        tick();
        fill_ack = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        bus.address = 24'h000000;
        bus.enable  = 1'b0;
        fill_ack    = 1'b0;
        fill_data   = 8'h00;
        fill_valid  = 1'b0;
        fill_done   = 1'b0;
        fill_error  = 1'b0;
        invalidate  = 1'b0;
        tick();
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_fill_req", fill_req, 1'b0);
        check("rst_fill_sector", fill_sector, 15'h0);
        check("rst_error", error, 1'b0);
        check("rst_fill_count", fill_count, 8'h00);
        check("rst_data_out", bus.data_out, 8'h00);
        reset = 1'b1;
        tick();

        // 1: cold miss, full sector with done on the last byte
        bus.address = 24'h010005;
        bus.enable  = 1'b1;
        #1;
        check("t1_miss_busy", bus.busy, 1'b1);
        tick();
        check("t1_fill_req", fill_req, 1'b1);
        check("t1_fill_sector", fill_sector, 15'h0080);
        ack();
        check("t1_req_dropped", fill_req, 1'b0);
        check("t1_fill_busy", bus.busy, 1'b1);
        stream(0, 512, 8'h00, 1'b1);
        check("t1_busy", bus.busy, 1'b0);
        check("t1_data", bus.data_out, 8'h05);
        check("t1_count", fill_count, 8'd1);
        check("t1_error", error, 1'b0);

        // 2: new byte in the line stalls one cycle, repeat does not
        bus.address = 24'h010006;
        #1;
        check("t2_stall", bus.busy, 1'b1);
        tick();
        check("t2_busy", bus.busy, 1'b0);
        check("t2_data", bus.data_out, 8'h06);
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        #1;
        check("t2_repeat_busy", bus.busy, 1'b0);
        check("t2_repeat_data", bus.data_out, 8'h06);
        check("t2_no_req", fill_req, 1'b0);

        // 3: next sector; extra byte after 512 must not wrap onto byte 0
        bus.address = 24'h010200;
        #1;
        check("t3_miss_busy", bus.busy, 1'b1);
        tick();
        check("t3_fill_req", fill_req, 1'b1);
        check("t3_fill_sector", fill_sector, 15'h0081);
        ack();
        stream(0, 512, 8'h5A, 1'b0);
        fill_valid = 1'b1;
        fill_data  = 8'hEE;
        tick();
        fill_valid = 1'b0;
        check("t3_still_filling", bus.busy, 1'b1);
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        check("t3_busy", bus.busy, 1'b0);
        check("t3_byte0", bus.data_out, 8'h5A);
        check("t3_count", fill_count, 8'd2);
        bus.address = 24'h0103FF;
        #1;
        check("t3_last_stall", bus.busy, 1'b1);
        tick();
        check("t3_last_data", bus.data_out, 8'hA5);
        bus.address = 24'h010005;
        #1;
        check("t3_old_misses", bus.busy, 1'b1);
        tick();
        check("t3_refill_req", fill_req, 1'b1);
        check("t3_refill_sector", fill_sector, 15'h0080);

        // 4: fill_error at byte 100, then retry
        ack();
        stream(0, 100, 8'h00, 1'b0);
        fill_error = 1'b1;
        tick();
        fill_error = 1'b0;
        check("t4_error", error, 1'b1);
        check("t4_busy", bus.busy, 1'b0);
        check("t4_data_ff", bus.data_out, 8'hFF);
        check("t4_count", fill_count, 8'd2);
        tick();
        check("t4_fail_hold", bus.data_out, 8'hFF);
        bus.enable = 1'b0;
        tick();
        check("t4_idle_busy", bus.busy, 1'b0);
        bus.enable = 1'b1;
        #1;
        check("t4_retry_busy", bus.busy, 1'b1);
        tick();
        check("t4_retry_req", fill_req, 1'b1);
        check("t4_error_sticky", error, 1'b1);
        ack();
        stream(0, 512, 8'h00, 1'b1);
        check("t4_error_clr", error, 1'b0);
        check("t4_count2", fill_count, 8'd3);
        check("t4_data", bus.data_out, 8'h05);

        // invalidate in IDLE drops the line; then a short sector fails
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("inv_idle_busy", bus.busy, 1'b1);
        bus.address = 24'h010400;
        tick();
        check("short_sector", fill_sector, 15'h0082);
        ack();
        stream(0, 10, 8'h00, 1'b1);
        check("short_error", error, 1'b1);
        check("short_data_ff", bus.data_out, 8'hFF);
        check("short_count", fill_count, 8'd3);
        bus.enable = 1'b0;
        tick();

        // 5: invalidate mid-fill
        bus.address = 24'h010005;
        bus.enable  = 1'b1;
        tick();
        check("t5_req", fill_req, 1'b1);
        ack();
        stream(0, 50, 8'h00, 1'b0);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        stream(50, 462, 8'h00, 1'b1);
        check("t5_count", fill_count, 8'd4);
        check("t5_still_miss", bus.busy, 1'b1);
        tick();
        check("t5_req_again", fill_req, 1'b1);

        // 6: reset mid-fill
        ack();
        stream(0, 20, 8'h00, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.enable = 1'b0;
        #1;
        check("t6_busy", bus.busy, 1'b0);
        check("t6_fill_req", fill_req, 1'b0);
        check("t6_fill_sector", fill_sector, 15'h0);
        check("t6_count", fill_count, 8'h00);
        check("t6_error", error, 1'b0);
        check("t6_data", bus.data_out, 8'h00);
        fill_valid = 1'b1;
        fill_data  = 8'h77;
        tick();
        fill_valid = 1'b0;
        check("t6_stray_busy", bus.busy, 1'b0);
        check("t6_stray_req", fill_req, 1'b0);
        bus.enable = 1'b1;
        #1;
        check("t6_miss_busy", bus.busy, 1'b1);
        tick();
        check("t6_req", fill_req, 1'b1);
        check("t6_sector", fill_sector, 15'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
